// File: rtl/pkt_queue_dma_writer_pkg.sv
// Shared types and sizing for the packet-queue DMA writer: flit, metadata and
// DMA request layouts, ring geometry, and the writer FSM encoding.
package pkt_queue_dma_writer_pkg;

  localparam int NB_QUEUES      = 512;
  localparam int FLOW_IDX_WIDTH = $clog2(NB_QUEUES);
  localparam int RB_SIZE        = 1024;
  localparam int PTR_W          = $clog2(RB_SIZE);
  localparam int SIZE_W         = 16;
  localparam int DATA_W         = 512;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              sop;
    logic              eop;
  } flit_lite_t;

  typedef struct packed {
    logic [FLOW_IDX_WIDTH-1:0] pkt_queue_id;
    logic [SIZE_W-1:0]         size;
  } pkt_meta_t;

  typedef struct packed {
    logic [63:0]       addr;
    logic [DATA_W-1:0] data;
    logic              sop;
    logic              eop;
  } dma_wr_req_t;

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP1, S_LOOKUP2, S_CHECK, S_XFER, S_DROP, S_DRAIN, S_NOTIFY
  } state_t;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/pkt_queue_dma_writer_queue_ptr_table.sv
// Per-queue {base, head, tail} table: one registered read port, and an
// independent write port per field so software and the writer never collide.
module pkt_queue_dma_writer_queue_ptr_table
  import pkt_queue_dma_writer_pkg::*;
(
  input  logic                      clk,
  input  logic [FLOW_IDX_WIDTH-1:0] rd_addr_i,
  output logic [63:0]               rd_base_o,
  output logic [PTR_W-1:0]          rd_head_o,
  output logic [PTR_W-1:0]          rd_tail_o,
  input  logic                      base_we_i,
  input  logic [FLOW_IDX_WIDTH-1:0] base_addr_i,
  input  logic [63:0]               base_wdata_i,
  input  logic                      head_we_i,
  input  logic [FLOW_IDX_WIDTH-1:0] head_addr_i,
  input  logic [PTR_W-1:0]          head_wdata_i,
  input  logic                      tail_we_i,
  input  logic [FLOW_IDX_WIDTH-1:0] tail_addr_i,
  input  logic [PTR_W-1:0]          tail_wdata_i
);

  logic [63:0]      base_mem [NB_QUEUES];
  logic [PTR_W-1:0] head_mem [NB_QUEUES];
  logic [PTR_W-1:0] tail_mem [NB_QUEUES];

  logic [63:0]      rd_base_q;
  logic [PTR_W-1:0] rd_head_q;
  logic [PTR_W-1:0] rd_tail_q;

  // A write landing on the address being read returns the new value.
  always_ff @(posedge clk) begin
    if (base_we_i) base_mem[base_addr_i] <= base_wdata_i;
    if (head_we_i) head_mem[head_addr_i] <= head_wdata_i;
    if (tail_we_i) tail_mem[tail_addr_i] <= tail_wdata_i;
    rd_base_q <= (base_we_i && base_addr_i == rd_addr_i) ? base_wdata_i : base_mem[rd_addr_i];
    rd_head_q <= (head_we_i && head_addr_i == rd_addr_i) ? head_wdata_i : head_mem[rd_addr_i];
    rd_tail_q <= (tail_we_i && tail_addr_i == rd_addr_i) ? tail_wdata_i : tail_mem[rd_addr_i];
  end

  assign rd_base_o = rd_base_q;
  assign rd_head_o = rd_head_q;
  assign rd_tail_o = rd_tail_q;

endmodule

// File: rtl/pkt_queue_dma_writer.sv
// Writes packets into per-queue host rings as 64 B DMA writes, drops packets
// that do not fit, and announces each advanced tail with a one-cycle pulse.
module pkt_queue_dma_writer
  import pkt_queue_dma_writer_pkg::*;
(
  input  logic                           clk,
  input  logic                           rst,
  input  logic [$bits(flit_lite_t)-1:0]  in_pkt_data,
  input  logic                           in_pkt_valid,
  output logic                           in_pkt_ready,
  input  logic [$bits(pkt_meta_t)-1:0]   in_meta_data,
  input  logic                           in_meta_valid,
  output logic                           in_meta_ready,
  input  logic                           cfg_wr_en,
  input  logic [FLOW_IDX_WIDTH-1:0]      cfg_queue_id,
  input  logic [63:0]                    cfg_base_addr,
  input  logic                           head_upd_valid,
  input  logic [FLOW_IDX_WIDTH-1:0]      head_upd_queue,
  input  logic [PTR_W-1:0]               head_upd_value,
  output logic [$bits(dma_wr_req_t)-1:0] dma_wr_data,
  output logic                           dma_wr_valid,
  input  logic                           dma_wr_ready,
  output logic [FLOW_IDX_WIDTH-1:0]      notif_queue_id,
  output logic [PTR_W-1:0]               notif_tail,
  output logic                           notif_valid,
  output logic [31:0]                    drop_cnt,
  output logic [31:0]                    err_cnt
);

  // Handshakes: a transfer happens on a rising edge where valid && ready; a
  // source holds valid and data stable until then. notif_valid has no ready.
  state_t                    state_q, state_d;
  logic [FLOW_IDX_WIDTH-1:0] id_q, id_d;
  logic [SIZE_W-1:0]         size_q, size_d, cnt_q, cnt_d, n_flits;
  logic [63:0]               base_q, base_d;
  logic [PTR_W-1:0]          head_q, head_d, tail_q, tail_d, cur_q, cur_d;
  dma_wr_req_t               dma_q, dma_d;
  logic                      dma_valid_q, dma_valid_d;
  logic [31:0]               drop_q, drop_d, err_q, err_d;
  logic [FLOW_IDX_WIDTH-1:0] sweep_q;
  logic                      sweep_busy_q;

  flit_lite_t                flit;
  pkt_meta_t                 meta;
  logic                      head_hit, tail_we;
  logic [PTR_W-1:0]          head_eff, free;
  logic [FLOW_IDX_WIDTH-1:0] rd_addr;
  logic [63:0]               rd_base;
  logic [PTR_W-1:0]          rd_head, rd_tail;

  assign flit     = in_pkt_data;
  assign meta     = in_meta_data;
  assign head_hit = head_upd_valid && (head_upd_queue == id_q);
  assign head_eff = head_hit ? head_upd_value : head_q;
  assign free     = head_eff - tail_q - PTR_W'(1);
  assign n_flits  = cnt_q + SIZE_W'(1);

  pkt_queue_dma_writer_queue_ptr_table u_table (
    .clk          (clk),
    .rd_addr_i    (rd_addr),
    .rd_base_o    (rd_base),
    .rd_head_o    (rd_head),
    .rd_tail_o    (rd_tail),
    .base_we_i    (sweep_busy_q | cfg_wr_en),
    .base_addr_i  (sweep_busy_q ? sweep_q : cfg_queue_id),
    .base_wdata_i (sweep_busy_q ? 64'd0 : cfg_base_addr),
    .head_we_i    (sweep_busy_q | head_upd_valid),
    .head_addr_i  (sweep_busy_q ? sweep_q : head_upd_queue),
    .head_wdata_i (sweep_busy_q ? '0 : head_upd_value),
    .tail_we_i    (sweep_busy_q | tail_we),
    .tail_addr_i  (sweep_busy_q ? sweep_q : id_q),
    .tail_wdata_i (sweep_busy_q ? '0 : cur_q)
  );

  always_comb begin
    state_d       = state_q;
    id_d          = id_q;
    size_d        = size_q;
    base_d        = base_q;
    head_d        = head_q;
    tail_d        = tail_q;
    cur_d         = cur_q;
    cnt_d         = cnt_q;
    dma_d         = dma_q;
    dma_valid_d   = dma_valid_q & ~dma_wr_ready;
    drop_d        = drop_q;
    err_d         = err_q;
    in_meta_ready = 1'b0;
    in_pkt_ready  = 1'b0;
    rd_addr       = id_q;
    tail_we       = 1'b0;
    notif_valid   = 1'b0;
    case (state_q)
      S_IDLE: begin
        in_meta_ready = !sweep_busy_q;
        rd_addr       = meta.pkt_queue_id;
        if (in_meta_valid && !sweep_busy_q) begin
          id_d    = meta.pkt_queue_id;
          size_d  = meta.size;
          state_d = S_LOOKUP1;
        end
      end
      S_LOOKUP1: begin
        base_d  = rd_base;
        tail_d  = rd_tail;
        head_d  = head_hit ? head_upd_value : rd_head;
        state_d = S_LOOKUP2;
      end
      S_LOOKUP2: begin
        head_d  = head_eff;
        state_d = S_CHECK;
      end
      S_CHECK: begin
        if (size_q == '0 || size_q > SIZE_W'(free)) begin
          state_d = S_DROP;
        end else begin
          cur_d   = tail_q;
          cnt_d   = '0;
          state_d = S_XFER;
        end
      end
      S_XFER: begin
        in_pkt_ready = dma_wr_ready | !dma_valid_q;
        if (in_pkt_valid && in_pkt_ready) begin
          dma_d       = {base_q + {{(64-PTR_W-6){1'b0}}, cur_q, 6'b0}, flit.data, flit.sop, flit.eop};
          dma_valid_d = 1'b1;
          cur_d       = cur_q + PTR_W'(1);
          cnt_d       = n_flits;
          if (flit.eop) begin
            if (n_flits == size_q) begin
              state_d = S_NOTIFY;
            end else begin
              err_d   = sat_inc(err_q);
              state_d = S_IDLE;
            end
          end else if (n_flits == size_q) begin
            // Metadata ran out before eop: swallow the rest without writing.
            err_d   = sat_inc(err_q);
            state_d = S_DRAIN;
          end
        end
      end
      S_DROP: begin
        in_pkt_ready = 1'b1;
        if (in_pkt_valid && flit.eop) begin
          drop_d  = sat_inc(drop_q);
          state_d = S_IDLE;
        end
      end
      S_DRAIN: begin
        in_pkt_ready = 1'b1;
        if (in_pkt_valid && flit.eop) state_d = S_IDLE;
      end
      S_NOTIFY: begin
        notif_valid = 1'b1;
        tail_we     = 1'b1;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      id_q         <= '0;
      size_q       <= '0;
      base_q       <= '0;
      head_q       <= '0;
      tail_q       <= '0;
      cur_q        <= '0;
      cnt_q        <= '0;
      dma_q        <= '0;
      dma_valid_q  <= 1'b0;
      drop_q       <= '0;
      err_q        <= '0;
      sweep_q      <= '0;
      sweep_busy_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      id_q        <= id_d;
      size_q      <= size_d;
      base_q      <= base_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      cur_q       <= cur_d;
      cnt_q       <= cnt_d;
      dma_q       <= dma_d;
      dma_valid_q <= dma_valid_d;
      drop_q      <= drop_d;
      err_q       <= err_d;
      if (sweep_busy_q) begin
        if (sweep_q == FLOW_IDX_WIDTH'(NB_QUEUES - 1)) sweep_busy_q <= 1'b0;
        sweep_q <= sweep_q + FLOW_IDX_WIDTH'(1);
      end
    end
  end

  assign dma_wr_data    = dma_q;
  assign dma_wr_valid   = dma_valid_q;
  assign notif_queue_id = id_q;
  assign notif_tail     = cur_q;
  assign drop_cnt       = drop_q;
  assign err_cnt        = err_q;

endmodule

// File: tb/tb_pkt_queue_dma_writer.sv
// Bench for pkt_queue_dma_writer: table of packet scenarios plus hand-written
// latency, backpressure and mid-packet reset sequences, checked by scoreboard.
`timescale 1ns/1ps
module tb_pkt_queue_dma_writer;
  import pkt_queue_dma_writer_pkg::*;

  localparam int DMA_W   = $bits(dma_wr_req_t);
  localparam int NOTIF_W = FLOW_IDX_WIDTH + PTR_W;
  localparam int K_OK = 0, K_DROP = 1, K_SHORT = 2, K_LONG = 3;
  localparam int NV = 11;

  logic                           clk = 1'b0;
  logic                           rst;
  logic [$bits(flit_lite_t)-1:0]  in_pkt_data;
  logic                           in_pkt_valid;
  logic                           in_pkt_ready;
  logic [$bits(pkt_meta_t)-1:0]   in_meta_data;
  logic                           in_meta_valid;
  logic                           in_meta_ready;
  logic                           cfg_wr_en;
  logic [FLOW_IDX_WIDTH-1:0]      cfg_queue_id;
  logic [63:0]                    cfg_base_addr;
  logic                           head_upd_valid;
  logic [FLOW_IDX_WIDTH-1:0]      head_upd_queue;
  logic [PTR_W-1:0]               head_upd_value;
  logic [DMA_W-1:0]               dma_wr_data;
  logic                           dma_wr_valid;
  logic                           dma_wr_ready;
  logic [FLOW_IDX_WIDTH-1:0]      notif_queue_id;
  logic [PTR_W-1:0]               notif_tail;
  logic                           notif_valid;
  logic [31:0]                    drop_cnt;
  logic [31:0]                    err_cnt;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  pkt_queue_dma_writer dut (
    .clk            (clk),
    .rst            (rst),
    .in_pkt_data    (in_pkt_data),
    .in_pkt_valid   (in_pkt_valid),
    .in_pkt_ready   (in_pkt_ready),
    .in_meta_data   (in_meta_data),
    .in_meta_valid  (in_meta_valid),
    .in_meta_ready  (in_meta_ready),
    .cfg_wr_en      (cfg_wr_en),
    .cfg_queue_id   (cfg_queue_id),
    .cfg_base_addr  (cfg_base_addr),
    .head_upd_valid (head_upd_valid),
    .head_upd_queue (head_upd_queue),
    .head_upd_value (head_upd_value),
    .dma_wr_data    (dma_wr_data),
    .dma_wr_valid   (dma_wr_valid),
    .dma_wr_ready   (dma_wr_ready),
    .notif_queue_id (notif_queue_id),
    .notif_tail     (notif_tail),
    .notif_valid    (notif_valid),
    .drop_cnt       (drop_cnt),
    .err_cnt        (err_cnt)
  );

  // ---------------- scoreboard state ----------------
  int checks   = 0;
  int failures = 0;
  logic [DMA_W-1:0]   exp_q[$];
  logic [NOTIF_W-1:0] exp_n_q[$];
  logic [511:0]       pkt_data_q[$];
  logic [63:0]        m_base [NB_QUEUES];
  logic [PTR_W-1:0]   m_tail [NB_QUEUES];
  int exp_drop = 0;
  int exp_err  = 0;

  typedef struct {
    int          q;
    logic [63:0] base;
    int          setup;
    int          head;
    int          size;
    int          nflits;
    int          kind;
    int          upd;
    int          upd_val;
    int          exp_tail;
  } vec_t;
  vec_t vec [NV];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic monitor();
    logic             stall_seen;
    logic [DMA_W-1:0] stall_data;
    logic [DMA_W-1:0] e;
    logic [NOTIF_W-1:0] en;
    stall_seen = 1'b0;
    stall_data = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (stall_seen && dma_wr_valid) begin
          checks++;
          if (dma_wr_data !== stall_data) begin
            failures++;
            $display("FAIL dma_stable: got %h expected %h", dma_wr_data, stall_data);
          end
        end
        stall_seen = dma_wr_valid && !dma_wr_ready;
        stall_data = dma_wr_data;
        if (dma_wr_valid && dma_wr_ready) begin
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL dma_unexpected: got addr %h expected no request", dma_wr_data[DMA_W-1 -: 64]);
          end else begin
            e = exp_q.pop_front();
            if (dma_wr_data !== e) begin
              failures++;
              $display("FAIL dma_req: got addr=%h sop=%b eop=%b expected addr=%h sop=%b eop=%b data_eq=%b",
                       dma_wr_data[DMA_W-1 -: 64], dma_wr_data[1], dma_wr_data[0],
                       e[DMA_W-1 -: 64], e[1], e[0], dma_wr_data[513:2] === e[513:2]);
            end
          end
        end
        if (notif_valid) begin
          checks++;
          if (exp_n_q.size() == 0) begin
            failures++;
            $display("FAIL notif_unexpected: got queue %0d tail %0d expected none", notif_queue_id, notif_tail);
          end else begin
            en = exp_n_q.pop_front();
            if ({notif_queue_id, notif_tail} !== en) begin
              failures++;
              $display("FAIL notif: got queue %0d tail %0d expected queue %0d tail %0d",
                       notif_queue_id, notif_tail, en[NOTIF_W-1 -: FLOW_IDX_WIDTH], en[PTR_W-1:0]);
            end
          end
        end
      end else begin
        stall_seen = 1'b0;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [511:0] rand_data();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  task automatic cfg_write(input int q, input logic [63:0] base);
    cfg_wr_en     = 1'b1;
    cfg_queue_id  = q[FLOW_IDX_WIDTH-1:0];
    cfg_base_addr = base;
    m_base[q]     = base;
    tick();
    cfg_wr_en = 1'b0;
  endtask

  task automatic head_pulse(input int q, input int h);
    head_upd_valid = 1'b1;
    head_upd_queue = q[FLOW_IDX_WIDTH-1:0];
    head_upd_value = h[PTR_W-1:0];
    tick();
    head_upd_valid = 1'b0;
  endtask

  task automatic send_meta(input int q, input int size);
    int n = 0;
    in_meta_data  = {q[FLOW_IDX_WIDTH-1:0], size[SIZE_W-1:0]};
    in_meta_valid = 1'b1;
    @(negedge clk);
    while (!in_meta_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!in_meta_ready) begin
      checks++;
      failures++;
      $display("FAIL meta_timeout: got in_meta_ready 0 expected 1 within 2000 cycles");
    end
    @(posedge clk);
    #1;
    in_meta_valid = 1'b0;
  endtask

  task automatic send_flit(input logic [511:0] d, input logic s, input logic e);
    int n = 0;
    in_pkt_data  = {d, s, e};
    in_pkt_valid = 1'b1;
    @(negedge clk);
    while (!in_pkt_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_pkt_ready) begin
      checks++;
      failures++;
      $display("FAIL flit_timeout: got in_pkt_ready 0 expected 1 within 200 cycles");
    end
    @(posedge clk);
    #1;
    in_pkt_valid = 1'b0;
  endtask

  // Build flit data and push every DMA request and notification it should cause.
  task automatic prepare(input int q, input int size, input int nflits, input int kind, input int exp_tail);
    logic [PTR_W-1:0] cur;
    logic [63:0]      a;
    logic [511:0]     d;
    int               ndma;
    cur  = m_tail[q];
    ndma = (kind == K_DROP) ? 0 : (kind == K_LONG) ? size : nflits;
    pkt_data_q.delete();
    for (int k = 0; k < nflits; k++) begin
      d = rand_data();
      pkt_data_q.push_back(d);
      if (k < ndma) begin
        a = m_base[q] + {48'd0, cur, 6'd0};
        exp_q.push_back({a, d, 1'(k == 0), 1'(k == nflits - 1)});
        cur = cur + PTR_W'(1);
      end
    end
    if (kind == K_OK) begin
      exp_n_q.push_back({q[FLOW_IDX_WIDTH-1:0], exp_tail[PTR_W-1:0]});
      m_tail[q] = exp_tail[PTR_W-1:0];
    end
    if (kind == K_DROP) exp_drop++;
    if (kind == K_SHORT || kind == K_LONG) exp_err++;
  endtask

  task automatic send_flits();
    for (int k = 0; k < pkt_data_q.size(); k++)
      send_flit(pkt_data_q[k], 1'(k == 0), 1'(k == pkt_data_q.size() - 1));
  endtask

  task automatic run_packet(input int q, input int size, input int nflits, input int kind,
                            input int exp_tail, input int upd, input int upd_val);
    prepare(q, size, nflits, kind, exp_tail);
    send_meta(q, size);
    if (upd != 0) head_pulse(q, upd_val);
    send_flits();
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || exp_n_q.size() != 0) && n < 3000) begin
      tick();
      n++;
    end
    if (n >= 3000) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: got %0d dma and %0d notif outstanding expected 0", exp_q.size(), exp_n_q.size());
      exp_q.delete();
      exp_n_q.delete();
    end
    repeat (4) tick();
  endtask

  task automatic reset_model();
    for (int i = 0; i < NB_QUEUES; i++) begin
      m_tail[i] = '0;
      m_base[i] = '0;
    end
    exp_drop = 0;
    exp_err  = 0;
  endtask

  task automatic release_and_sweep();
    int k = 0;
    rst = 1'b1;
    while (!in_meta_ready && k < 2000) begin
      tick();
      k++;
    end
    check("sweep_cycles", k, 512);
  endtask

  // ---------------- test ----------------
  initial begin
    int k;
    rst            = 1'b0;
    in_pkt_data    = '0;
    in_pkt_valid   = 1'b0;
    in_meta_data   = '0;
    in_meta_valid  = 1'b0;
    cfg_wr_en      = 1'b0;
    cfg_queue_id   = '0;
    cfg_base_addr  = '0;
    head_upd_valid = 1'b0;
    head_upd_queue = '0;
    head_upd_value = '0;
    dma_wr_ready   = 1'b1;
    reset_model();

    //            q   base             setup head size nfl kind     upd val tail
    vec[0]  = '{  3, 64'h1000_0000,    0,    0,   2,   2,  K_OK,    0,  0,  2};
    vec[1]  = '{  7, 64'h2000_0000, 1022,    5,   4,   4,  K_OK,    0,  0,  2};
    vec[2]  = '{  9, 64'h3000_0000,    5,   10,   5,   5,  K_DROP,  0,  0,  5};
    vec[3]  = '{  9, 64'h3000_0000,    0,   10,   4,   4,  K_OK,    0,  0,  9};
    vec[4]  = '{ 11, 64'h4000_0000,    5,   10,   5,   5,  K_OK,    1, 20, 10};
    vec[5]  = '{ 12, 64'h4100_0000,    0,    0,   0,   1,  K_DROP,  0,  0,  0};
    vec[6]  = '{ 13, 64'h4200_0000,    0,    4,   3,   3,  K_OK,    0,  0,  3};
    vec[7]  = '{ 14, 64'h4300_0000,    0,    4,   4,   4,  K_DROP,  0,  0,  0};
    vec[8]  = '{ 21, 64'h4400_0000,    0,    0,   3,   2,  K_SHORT, 0,  0,  0};
    vec[9]  = '{ 21, 64'h4400_0000,    0,    0,   2,   2,  K_OK,    0,  0,  2};
    vec[10] = '{ 22, 64'h4500_0000,    0,    0,   2,   4,  K_LONG,  0,  0,  0};

    fork
      monitor();
    join_none

    repeat (3) tick();
    check("rst_meta_ready", in_meta_ready, 0);
    check("rst_pkt_ready",  in_pkt_ready,  0);
    check("rst_dma_valid",  dma_wr_valid,  0);
    check("rst_notif",      notif_valid,   0);
    check("rst_drop_cnt",   drop_cnt,      0);
    check("rst_err_cnt",    err_cnt,       0);
    release_and_sweep();

    // Meta accept to first DMA request
    cfg_write(2, 64'h0800_0000);
    prepare(2, 1, 1, K_OK, 1);
    send_meta(2, 1);
    fork
      send_flits();
      begin
        k = 0;
        while (!dma_wr_valid && k < 20) begin
          tick();
          k++;
        end
        check("latency_meta_to_dma", k, 4);
      end
    join
    wait_idle();

    for (int i = 0; i < NV; i++) begin
      cfg_write(vec[i].q, vec[i].base);
      if (vec[i].setup > 0) begin
        head_pulse(vec[i].q, 0);
        run_packet(vec[i].q, vec[i].setup, vec[i].setup, K_OK, vec[i].setup, 0, 0);
      end
      head_pulse(vec[i].q, vec[i].head);
      run_packet(vec[i].q, vec[i].size, vec[i].nflits, vec[i].kind, vec[i].exp_tail,
                 vec[i].upd, vec[i].upd_val);
      wait_idle();
      check($sformatf("row%0d_drop_cnt", i), drop_cnt, exp_drop);
      check($sformatf("row%0d_err_cnt", i),  err_cnt,  exp_err);
    end

    // Backpressure: DMA ready low for 10 cycles mid-packet
    cfg_write(20, 64'h5000_0000);
    head_pulse(20, 0);
    prepare(20, 6, 6, K_OK, 6);
    send_meta(20, 6);
    fork
      send_flits();
      begin
        repeat (5) tick();
        dma_wr_ready = 1'b0;
        for (int j = 0; j < 10; j++) begin
          @(negedge clk);
          check("stall_pkt_ready", in_pkt_ready, 0);
          check("stall_dma_valid", dma_wr_valid, 1);
          @(posedge clk);
          #1;
        end
        dma_wr_ready = 1'b1;
      end
    join
    wait_idle();

    // Reset in the middle of a transfer
    cfg_write(23, 64'h6000_0000);
    head_pulse(23, 0);
    send_meta(23, 6);
    dma_wr_ready = 1'b0;
    in_pkt_data  = {rand_data(), 1'b1, 1'b0};
    in_pkt_valid = 1'b1;
    repeat (6) tick();
    check("xfer_dma_valid", dma_wr_valid, 1);
    rst          = 1'b0;
    in_pkt_valid = 1'b0;
    tick();
    tick();
    check("mid_rst_dma_valid",  dma_wr_valid,  0);
    check("mid_rst_meta_ready", in_meta_ready, 0);
    check("mid_rst_pkt_ready",  in_pkt_ready,  0);
    check("mid_rst_notif",      notif_valid,   0);
    check("mid_rst_err_cnt",    err_cnt,       0);
    check("mid_rst_drop_cnt",   drop_cnt,      0);
    dma_wr_ready = 1'b1;
    reset_model();
    release_and_sweep();

    cfg_write(3, 64'h1000_0000);
    run_packet(3, 2, 2, K_OK, 2, 0, 0);
    wait_idle();
    check("post_rst_err_cnt", err_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
